ula_sequenciador: RTL and testbench

- Multi-cycle issue/writeback stage placed directly upstream of the ULA.
- Accepts 16-bit instructions over a valid/ready handshake and holds an 8x16 register bank.
- Drives the ULA operand and control inputs, waits a fixed ULA latency, then writes resultadoOp back into the destination register.
- Provides the sequencing the ULA lacks, turning it into an executable datapath.

---
 rtl/ula_pkg.sv | 44 ++++
 rtl/ula_banco_regs.sv | 42 ++++
 rtl/ula_sequenciador.sv | 172 +++++++++++++++++
 tb/tb_ula_sequenciador.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA issue/writeback stage: instruction fields,
// FSM state encoding and the decoded-instruction record.
package ula_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 5;
  localparam int REG_AW  = 3;
  localparam int IMM_W   = 8;

  localparam int OPC_LSB = 11;
  localparam int RD_LSB  = 8;
  localparam int RA_LSB  = 5;
  localparam int RB_LSB  = 2;
  localparam int IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OPC_LOADI = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [IMM_W-1:0]  imm;
  } instr_t;

  // The immediate overlaps ra/rb and the two reserved bits; both views are kept.
  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.opcode = w[OPC_LSB +: OPC_W];
    d.rd     = w[RD_LSB +: REG_AW];
    d.ra     = w[RA_LSB +: REG_AW];
    d.rb     = w[RB_LSB +: REG_AW];
    d.imm    = w[IMM_LSB +: IMM_W];
    return d;
  endfunction

endpackage

// File: rtl/ula_banco_regs.sv
// Register bank: two combinational read ports, one synchronous write port,
// R0 hardwired to zero, asynchronous active-low clear of every entry.
module ula_banco_regs #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/ula_sequenciador.sv
// Issue/writeback sequencer in front of the ULA: IDLE -> DECODE -> EXEC -> WB.
// Optional condition flags (flag_zero/flag_neg) are built with ULA_SEQ_FLAGS_EN.
module ula_sequenciador
  import ula_pkg::*;
#(
  parameter int DW      = 16,
  parameter int NREG    = 8,
  parameter int ULA_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DW-1:0]      operandoA,
  output logic [DW-1:0]      operandoB,
  output logic [OPC_W-1:0]   controle,
  input  logic [DW-1:0]      resultadoOp,
  output logic               busy,
`ifdef ULA_SEQ_FLAGS_EN
  output logic               flag_zero,
  output logic               flag_neg,
`endif
  output logic               done,
  output state_t             state_dbg
);

  localparam int CNT_W = (ULA_LAT > 1) ? $clog2(ULA_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ULA_LAT - 1);

  state_t             state_q, state_d;
  instr_t             dec_q, dec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      res_q, res_d;
  logic [DW-1:0]      opa_q, opa_d;
  logic [DW-1:0]      opb_q, opb_d;
  logic [OPC_W-1:0]   ctl_q, ctl_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [DW-1:0]      rdata_a, rdata_b;
  logic               is_loadi;
  logic               accept;

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_valid is don't-care while instr_ready is low.
  assign accept   = instr_valid && ready_q;
  assign is_loadi = (dec_q.opcode == OPC_LOADI);

  ula_banco_regs #(
    .DW   (DW),
    .NREG (NREG)
  ) u_banco (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (state_q == ST_WB),
    .waddr   (dec_q.rd),
    .wdata   (res_q),
    .raddr_a (dec_q.ra),
    .rdata_a (rdata_a),
    .raddr_b (dec_q.rb),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dec_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      ctl_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      ctl_q   <= ctl_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_DECODE;
      ST_DECODE: state_d = is_loadi ? ST_WB : ST_EXEC;
      ST_EXEC:   if (cnt_q == CNT_LAST) state_d = ST_WB;
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Handshake/status outputs are registered from the next state so they stay glitch-free.
  always_comb begin
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    ctl_d   = ctl_q;
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_WB);
    case (state_q)
      ST_IDLE: begin
        if (accept) dec_d = decode_instr(instr);
      end
      ST_DECODE: begin
        cnt_d = '0;
        if (is_loadi) begin
          res_d = DW'(dec_q.imm);
        end else begin
          opa_d = rdata_a;
          opb_d = rdata_b;
          ctl_d = dec_q.opcode;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) res_d = resultadoOp;
      end
      default: ;
    endcase
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign operandoA   = opa_q;
  assign operandoB   = opb_q;
  assign controle    = ctl_q;
  assign state_dbg   = state_q;

`ifdef ULA_SEQ_FLAGS_EN
  logic zero_q, zero_d;
  logic neg_q, neg_d;

  // Flags follow every writeback, including discarded R0 writes and LOADI.
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    if (state_q == ST_WB) begin
      zero_d = (res_q == '0);
      neg_d  = res_q[DW-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign flag_zero = zero_q;
  assign flag_neg  = neg_q;
`endif

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed bench for ula_sequenciador; a small ULA model answers resultadoOp.
module tb_ula_sequenciador;
  import ula_pkg::*;

`ifdef ULA_SEQ_FLAGS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [15:0] operandoA, operandoB, resultadoOp;
  logic [4:0]  controle;
  logic        busy, done;
  state_t      state_dbg;
`ifdef ULA_SEQ_FLAGS_EN
  logic        flag_zero, flag_neg;
`endif

  ula_sequenciador #(
    .DW      (16),
    .NREG    (8),
    .ULA_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .operandoA   (operandoA),
    .operandoB   (operandoB),
    .controle    (controle),
    .resultadoOp (resultadoOp),
    .busy        (busy),
`ifdef ULA_SEQ_FLAGS_EN
    .flag_zero   (flag_zero),
    .flag_neg    (flag_neg),
`endif
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // Clock / reset support
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ULA stand-in: 0 add, 1 sub, 2 and, 3 or, 4 xor, 6 shift left by 8
  function automatic logic [15:0] ula_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [4:0] c);
    case (c)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd6:    return {a[7:0], 8'h00};
      default: return a;
    endcase
  endfunction

  assign resultadoOp = ula_model(operandoA, operandoB, controle);

  // Scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk_alu(input logic [4:0] opc, input int rd, input int ra,
                                         input int rb);
    return {opc, 3'(rd), 3'(ra), 3'(rb), 2'b00};
  endfunction

  function automatic logic [15:0] mk_loadi(input int rd, input logic [7:0] imm);
    return {OPC_LOADI, 3'(rd), imm};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] obs_a, obs_b;
  logic [4:0]  obs_c;
  int          lat;

  // Issues one instruction, returns with lat = cycles from accept to done cycle,
  // EXEC-cycle operands in obs_*, and the block back in IDLE.
  task automatic send(input logic [15:0] w);
    int guard;
    guard = 0;
    while (!instr_ready && guard < 50) begin
      tick();
      guard++;
    end
    check_val("send_ready", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr = w;
    tick();
    instr_valid = 1'b0;
    instr = 16'($urandom_range(0, 65535));
    lat = 1;
    while (!done && lat < 50) begin
      tick();
      lat++;
      if (lat == 2 && w[15:11] != OPC_LOADI) begin
        obs_a = operandoA;
        obs_b = operandoB;
        obs_c = controle;
      end
    end
    tick();
    check_val("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic check_ops(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] c);
    check_val({tag, "_lat"}, 32'(lat), 32'(2 + LAT));
    check_val({tag, "_opA"}, 32'(obs_a), 32'(a));
    check_val({tag, "_opB"}, 32'(obs_b), 32'(b));
    check_val({tag, "_ctl"}, 32'(obs_c), 32'(c));
  endtask

  // Back-to-back table
  logic [15:0] b2b_instr [7];
  logic        b2b_alu   [7];

  initial begin
    int low, dones, guard;
    logic [31:0] exp_v;
    logic        done_seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", 32'(instr_ready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_opA", 32'(operandoA), 32'd0);
    check_val("rst_opB", 32'(operandoB), 32'd0);
    check_val("rst_ctl", 32'(controle), 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("rel_ready_before_edge", 32'(instr_ready), 32'd0);
    tick();
    check_val("rel_ready_first_edge", 32'(instr_ready), 32'd1);
    check_val("rel_busy", 32'(busy), 32'd0);

    // LOADI R1,0x34 then read it back as operand
    send(mk_loadi(1, 8'h34));
    check_val("loadi_lat", 32'(lat), 32'd2);
    send(mk_alu(5'd0, 4, 1, 0));
    check_ops("read_r1", 16'h0034, 16'h0000, 5'd0);

    // Basic ALU flow
    send(mk_loadi(1, 8'd5));
    send(mk_loadi(2, 8'd3));
    send(mk_alu(5'd0, 3, 1, 2));
    check_ops("add_r3", 16'd5, 16'd3, 5'd0);
    send(mk_alu(5'd2, 5, 3, 3));
    check_ops("and_r5", 16'd8, 16'd8, 5'd2);
    send(mk_alu(5'd1, 6, 5, 1));
    check_ops("sub_r6", 16'd8, 16'd5, 5'd1);

    // R0 write discarded, done still pulses, ULA controls held by LOADI
    send(mk_loadi(0, 8'hFF));
    check_val("loadi_r0_lat", 32'(lat), 32'd2);
    check_val("loadi_holds_ctl", 32'(controle), 32'd1);
    check_val("loadi_holds_opA", 32'(operandoA), 32'd8);
    send(mk_alu(5'd3, 7, 0, 6));
    check_ops("read_r0", 16'd0, 16'd3, 5'd3);

    // Same register as ra, rb and rd
    send(mk_alu(5'd0, 2, 2, 2));
    check_ops("same_reg", 16'd3, 16'd3, 5'd0);
    send(mk_alu(5'd4, 1, 2, 7));
    check_ops("same_reg_rd", 16'd6, 16'd3, 5'd4);

    // Immediate is zero-extended
    send(mk_loadi(4, 8'hFF));
    send(mk_alu(5'd0, 5, 4, 1));
    check_ops("imm_zext", 16'h00FF, 16'd5, 5'd0);

    // Back-to-back with instr_valid held high
    b2b_instr[0] = mk_loadi(1, 8'h11);   b2b_alu[0] = 1'b0;
    b2b_instr[1] = mk_loadi(2, 8'h22);   b2b_alu[1] = 1'b0;
    b2b_instr[2] = mk_alu(5'd0, 3, 1, 2); b2b_alu[2] = 1'b1;
    b2b_instr[3] = mk_alu(5'd0, 4, 3, 1); b2b_alu[3] = 1'b1;
    b2b_instr[4] = mk_alu(5'd4, 5, 4, 2); b2b_alu[4] = 1'b1;
    b2b_instr[5] = mk_alu(5'd1, 6, 5, 3); b2b_alu[5] = 1'b1;
    b2b_instr[6] = mk_alu(5'd0, 0, 6, 6); b2b_alu[6] = 1'b1;
    exp_q.push_back({16'h0011, 16'h0022});
    exp_q.push_back({16'h0033, 16'h0011});
    exp_q.push_back({16'h0044, 16'h0022});
    exp_q.push_back({16'h0066, 16'h0033});
    exp_q.push_back({16'h0033, 16'h0033});
    guard = 0;
    while (!instr_ready && guard < 50) begin
      tick();
      guard++;
    end
    instr_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      instr = b2b_instr[i];
      tick();
      low = 0;
      dones = 0;
      while (!instr_ready && low < 50) begin
        low++;
        if (done) dones++;
        if (low == 2 && b2b_alu[i]) begin
          if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check_val($sformatf("b2b_ops_%0d", i), {operandoA, operandoB}, exp_v);
          end else begin
            check_val($sformatf("b2b_queue_%0d", i), 32'(exp_q.size()), 32'd1);
          end
        end
        tick();
      end
      check_val($sformatf("b2b_low_%0d", i), 32'(low), b2b_alu[i] ? 32'(2 + LAT) : 32'd2);
      check_val($sformatf("b2b_done_%0d", i), 32'(dones), 32'd1);
      if (i == 6) instr_valid = 1'b0;
    end
    tick();
    check_val("b2b_no_dup", 32'(busy), 32'd0);
    check_val("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    send(mk_alu(5'd0, 7, 6, 0));
    check_ops("b2b_r0_intact", 16'h0033, 16'h0000, 5'd0);

    // Reset during EXEC
    instr_valid = 1'b1;
    instr = mk_alu(5'd0, 7, 1, 2);
    tick();
    instr_valid = 1'b0;
    tick();
    check_val("mid_busy", 32'(busy), 32'd1);
    check_val("mid_opA", 32'(operandoA), 32'h11);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_opA", 32'(operandoA), 32'd0);
    check_val("arst_opB", 32'(operandoB), 32'd0);
    check_val("arst_ctl", 32'(controle), 32'd0);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_ready", 32'(instr_ready), 32'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) done_seen = 1'b1;
    end
    check_val("arst_no_done", 32'(done_seen), 32'd0);
    rst_n = 1'b1;
    tick();
    check_val("arst_ready_after", 32'(instr_ready), 32'd1);
    send(mk_alu(5'd0, 3, 7, 1));
    check_ops("arst_r7_clear", 16'd0, 16'd0, 5'd0);

`ifdef ULA_SEQ_FLAGS_EN
    check_val("flags_after_zero_result", 32'({flag_zero, flag_neg}), 32'b10);
    send(mk_loadi(1, 8'h80));
    check_val("flag_loadi_pos", 32'({flag_zero, flag_neg}), 32'b00);
    send(mk_alu(5'd6, 2, 1, 0));
    check_ops("flag_shl", 16'h0080, 16'h0000, 5'd6);
    check_val("flag_neg_8000", 32'({flag_zero, flag_neg}), 32'b01);
    send(mk_alu(5'd1, 3, 2, 2));
    check_val("flag_zero_sub", 32'({flag_zero, flag_neg}), 32'b10);
    send(mk_loadi(0, 8'h01));
    check_val("flag_r0_loadi", 32'({flag_zero, flag_neg}), 32'b00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
